// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the pipeline interlock scoreboard.
package hazard_scoreboard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         SB_DEPTH = 3;

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, dst: REG_ZERO};

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW interlock for a forwarding-less 5-stage pipeline: tracks in-flight
// destinations in EX/MEM/WB, stalls ID on a hit, squashes on taken branches.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_reg_write,
  input  logic [4:0]       id_dest,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  sb_entry_t         sb_reg [SB_DEPTH];
  logic [SB_DEPTH-1:0] rs_match;
  logic [SB_DEPTH-1:0] rt_match;
  logic              hit_rs;
  logic              hit_rt;
  logic              issue;

  // With a write-before-read register file the WB slot is already visible.
  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_cmp
      localparam bit SLOT_LIVE = (gi != SLOT_WB) || !WB_BYPASS;
      assign rs_match[gi] = SLOT_LIVE && sb_reg[gi].vld && (sb_reg[gi].dst == id_rs);
      assign rt_match[gi] = SLOT_LIVE && sb_reg[gi].vld && (sb_reg[gi].dst == id_rt);
    end
  endgenerate

  assign hit_rs = id_use_rs && (id_rs != REG_ZERO) && (|rs_match);
  assign hit_rt = id_use_rt && (id_rt != REG_ZERO) && (|rt_match);

  // A taken branch means ID is on the wrong path: squash it, never hold it.
  assign stall       = id_valid && (hit_rs || hit_rt) && !ex_branch_taken;
  assign bubble_idex = stall || ex_branch_taken;
  assign flush_ifid  = ex_branch_taken;

  assign issue = id_valid && id_reg_write && (id_dest != REG_ZERO) &&
                 !stall && !ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_reg[i] <= SB_EMPTY;
      end
    end else begin
      for (int i = SB_DEPTH - 1; i > 0; i--) begin
        sb_reg[i] <= sb_reg[i-1];
      end
      sb_reg[SLOT_EX] <= issue ? sb_entry_t'{vld: 1'b1, dst: id_dest} : SB_EMPTY;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ex_branch_taken),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Pipeline interlock controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB). The datapath has no forwarding, so this block sequences it.
- Keeps a 3-slot scoreboard of in-flight destination registers (EX, MEM, WB).
- Stalls the instruction in ID on a RAW dependency.
- Inserts bubbles into ID/EX.
- Flushes IF/ID on a taken branch.
- Counts stall and flush events for debug.
It lets programs run without hand-inserted NOPs.

Parameters:
- WB_BYPASS, 0: 1 means the register file writes before it reads in the same cycle, so the WB slot never causes a hazard.
- CNT_W, 16: width of the saturating event counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- id_valid  in  1  ID stage holds a real instruction (not a bubble or NOP)
- id_rs  in  5  source register A of the ID instruction (inst[25:21])
- id_rt  in  5  source register B of the ID instruction (inst[20:16])
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt (R-type, SW, BEQ)
- id_reg_write  in  1  ID instruction writes a register
- id_dest  in  5  final destination register of the ID instruction (after the RegDst mux)
- ex_branch_taken  in  1  branch resolved as taken in EX this cycle
- stall  out  1  hold PC and IF/ID this cycle
- bubble_idex  out  1  load a NOP (all controls 0) into ID/EX at the next edge
- flush_ifid  out  1  load a NOP into IF/ID at the next edge
- stall_cnt  out  CNT_W  cycles spent stalled, saturating
- flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Scoreboard: three entries, slot[0]=EX, slot[1]=MEM, slot[2]=WB.
  - Each entry holds {vld, dst[4:0]}.
  - On reset every entry is vld=0, dst=0.
- Every rising edge with rst low:
  - slot[2] takes slot[1]; slot[1] takes slot[0].
  - slot[0] takes {1, id_dest} when issue is true, otherwise {0, 0}.
  - issue = id_valid AND id_reg_write AND (id_dest != 0) AND NOT stall AND NOT ex_branch_taken.
- Hazard (combinational, same cycle): for each source X in {rs, rt}, a hit occurs when all of these hold:
  - id_use_X = 1;
  - X != 0;
  - some slot k has vld=1 and dst == X;
  - k <= 1, or k = 2 with WB_BYPASS = 0.
  - Register $0 never causes a hazard.
- stall = id_valid AND (hit on rs OR hit on rt) AND NOT ex_branch_taken.
- bubble_idex = stall OR ex_branch_taken.
- flush_ifid = ex_branch_taken.
- Priority: a taken branch beats a stall. The ID instruction is on the wrong path, so it is squashed rather than held.
- Latency:
  - A producer in ID followed by a dependent in the next instruction causes 3 stall cycles (WB_BYPASS=0) or 2 (WB_BYPASS=1).
  - A load-use pair behaves the same, because loads occupy slots the same way.
- Stall is never more than 3 consecutive cycles for a single dependency. No deadlock: bubbles always drain the scoreboard.
- Counters:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with ex_branch_taken=1.
  - Both hold at all-ones and do not wrap.
- Reset values: stall=0, bubble_idex=0, flush_ifid=0 (all valid inputs low after reset), stall_cnt=0, flush_cnt=0.
- Reset asserted mid-stall: the scoreboard and counters clear immediately (asynchronously), and stall drops in the same cycle.
- id_valid=0 while slots are busy: no stall and no issue, but slots keep shifting.

Decomposition:
- Shared package constants:
  - REG_ZERO = 5'd0;
  - SB_DEPTH = 3;
  - slot indices SLOT_EX=0, SLOT_MEM=1, SLOT_WB=2;
  - the scoreboard entry struct {vld, dst}.
- One natural sub-module: sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice.
- The scoreboard shift register and hit comparators stay inline.

Test Plan:
- ADDI $10,$0,5 issued, then ADD $12,$10,$11 in ID on the next cycle, WB_BYPASS=0 -> stall=1 for exactly 3 cycles, 3 bubbles into ID/EX, stall_cnt=3, ADD proceeds on cycle 4.
- Same sequence with WB_BYPASS=1 -> stall for 2 cycles, stall_cnt=2.
- LW $11,20($0), then NOP, then ADD $12,$10,$11 (WB_BYPASS=0) -> stall for 2 cycles only, since the NOP already drained one slot.
- ADDI $0,$0,5 followed by an instruction reading $0 -> stall stays 0 and no slot is marked valid.
- Dependent instruction stalled in ID while ex_branch_taken=1 -> stall=0, flush_ifid=1, bubble_idex=1 that cycle, flush_cnt=1, squashed instruction not issued.
- rst pulsed during the second stall cycle -> stall, slots and counters read 0 immediately. Force stall_cnt to 16'hFFFE, run 3 stall cycles -> stall_cnt=16'hFFFF.
